nc_data_bridge: RTL

Memory-side bridge sitting directly downstream of the NanoCore data port (`data_req`/`data_gnt`/`data_ready`). It decodes each accepted core access into one of three regions: on-chip data SRAM (single-cycle synchronous), MMIO peripheral bus (variable-latency, ack-based, with timeout), or unmapped (error). It returns exactly one `data_ready_o` pulse per granted request. At most one access is outstanding; back-to-back SRAM accesses sustain one per cycle.

---
 rtl/nc_data_bridge_pkg.sv | 28 ++
 rtl/nc_data_bridge_addr_decode.sv | 30 +++
 rtl/nc_data_bridge.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/nc_data_bridge_pkg.sv
// Shared types and default constants for the NanoCore data-side bridge.
package nc_data_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SRAM_RSP = 3'd1,
    ST_PER_WAIT = 3'd2,
    ST_PER_RSP  = 3'd3,
    ST_ERR_RSP  = 3'd4
  } nc_dbr_state_t;

  typedef enum logic [1:0] {
    REG_SRAM = 2'd0,
    REG_MMIO = 2'd1,
    REG_NONE = 2'd2
  } nc_region_t;

  localparam int unsigned NC_SRAM_AW_DEF   = 14;
  localparam int unsigned NC_TIMEOUT_DEF   = 16;
  localparam logic [31:0] NC_MMIO_BASE_DEF = 32'h1000_0000;
  localparam logic [31:0] NC_MMIO_MASK_DEF = 32'hF000_0000;

  // Byte-lane write enables: reads never assert a lane.
  function automatic logic [3:0] nc_lane_we(input logic we, input logic [3:0] wstrb);
    return we ? wstrb : 4'h0;
  endfunction

endpackage

// File: rtl/nc_data_bridge_addr_decode.sv
// Combinational address-to-region decoder; SRAM wins over MMIO, anything else is unmapped.
module nc_addr_decode
  import nc_data_bridge_pkg::*;
#(
  parameter int unsigned SRAM_AW   = NC_SRAM_AW_DEF,
  parameter logic [31:0] MMIO_BASE = NC_MMIO_BASE_DEF,
  parameter logic [31:0] MMIO_MASK = NC_MMIO_MASK_DEF
) (
  input  logic [31:0] i_addr,
  output nc_region_t  o_region
);

  logic w_sram_hit;
  logic w_mmio_hit;

  assign w_sram_hit = (i_addr[31:SRAM_AW+2] == {(30-SRAM_AW){1'b0}});
  assign w_mmio_hit = ((i_addr & MMIO_MASK) == MMIO_BASE);

  always_comb begin
    o_region = REG_NONE;
    if (w_sram_hit) begin
      o_region = REG_SRAM;
    end else if (w_mmio_hit) begin
      o_region = REG_MMIO;
    end else begin
      o_region = REG_NONE;
    end
  end

endmodule

// File: rtl/nc_data_bridge.sv
// NanoCore data-port bridge: routes each granted access to SRAM, the MMIO bus or an
// error response, returning exactly one data_ready_o pulse per grant.
module nc_data_bridge
  import nc_data_bridge_pkg::*;
#(
  parameter int unsigned SRAM_AW   = NC_SRAM_AW_DEF,
  parameter logic [31:0] MMIO_BASE = NC_MMIO_BASE_DEF,
  parameter logic [31:0] MMIO_MASK = NC_MMIO_MASK_DEF,
  parameter int unsigned TIMEOUT   = NC_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               data_req_i,
  input  logic               data_we_i,
  input  logic [31:0]        data_addr_i,
  input  logic [3:0]         data_wstrb_i,
  input  logic [31:0]        data_wdata_i,
  output logic               data_gnt_o,
  output logic               data_ready_o,
  output logic [31:0]        data_rdata_o,
  output logic               sram_en_o,
  output logic [3:0]         sram_we_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [31:0]        sram_wdata_o,
  input  logic [31:0]        sram_rdata_i,
  output logic               per_req_o,
  output logic               per_we_o,
  output logic [31:0]        per_addr_o,
  output logic [3:0]         per_wstrb_o,
  output logic [31:0]        per_wdata_o,
  input  logic               per_ack_i,
  input  logic [31:0]        per_rdata_i,
  output logic               err_o,
  output logic [31:0]        err_addr_o
);

  localparam int unsigned    CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  nc_dbr_state_t r_state;
  logic [CW-1:0] r_wait;
  logic          r_rsp_we;
  logic          r_per_req;
  logic          r_per_we;
  logic [31:0]   r_per_addr;
  logic [3:0]    r_per_wstrb;
  logic [31:0]   r_per_wdata;
  logic [31:0]   r_per_rdata;
  logic [31:0]   r_err_addr;

  nc_region_t    w_region;
  logic          w_accept;
  logic          w_sram_hit;

  nc_addr_decode #(
    .SRAM_AW   (SRAM_AW),
    .MMIO_BASE (MMIO_BASE),
    .MMIO_MASK (MMIO_MASK)
  ) u_decode (
    .i_addr   (data_addr_i),
    .o_region (w_region)
  );

  // resetn gates the grant, so nothing below can fire while reset is asserted.
  assign data_gnt_o = resetn & (r_state != ST_PER_WAIT);
  assign w_accept   = data_req_i & data_gnt_o;
  assign w_sram_hit = w_accept & (w_region == REG_SRAM);

  assign sram_en_o    = w_sram_hit;
  assign sram_we_o    = w_sram_hit ? nc_lane_we(data_we_i, data_wstrb_i) : 4'h0;
  assign sram_addr_o  = w_sram_hit ? data_addr_i[SRAM_AW+1:2] : {SRAM_AW{1'b0}};
  assign sram_wdata_o = w_sram_hit ? data_wdata_i : 32'h0;

  assign data_ready_o = (r_state == ST_SRAM_RSP) | (r_state == ST_PER_RSP) |
                        (r_state == ST_ERR_RSP);
  assign err_o        = (r_state == ST_ERR_RSP);
  assign err_addr_o   = r_err_addr;

  assign per_req_o    = r_per_req;
  assign per_we_o     = r_per_we;
  assign per_addr_o   = r_per_addr;
  assign per_wstrb_o  = r_per_wstrb;
  assign per_wdata_o  = r_per_wdata;

  // SRAM read data is forwarded live because the macro presents it the cycle after enable.
  always_comb begin
    data_rdata_o = 32'h0;
    case (r_state)
      ST_SRAM_RSP: data_rdata_o = r_rsp_we ? 32'h0 : sram_rdata_i;
      ST_PER_RSP:  data_rdata_o = r_rsp_we ? 32'h0 : r_per_rdata;
      default:     data_rdata_o = 32'h0;
    endcase
  end

  // Bridge sequencer: response states double as accept slots for the next request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_wait      <= {CW{1'b0}};
      r_rsp_we    <= 1'b0;
      r_per_req   <= 1'b0;
      r_per_we    <= 1'b0;
      r_per_addr  <= 32'h0;
      r_per_wstrb <= 4'h0;
      r_per_wdata <= 32'h0;
      r_per_rdata <= 32'h0;
      r_err_addr  <= 32'h0;
    end else begin
      case (r_state)
        ST_PER_WAIT: begin
          if (per_ack_i) begin
            r_per_req   <= 1'b0;
            r_per_rdata <= per_rdata_i;
            r_state     <= ST_PER_RSP;
          end else if (r_wait == TMO_LAST) begin
            r_per_req  <= 1'b0;
            r_err_addr <= r_per_addr;
            r_state    <= ST_ERR_RSP;
          end else begin
            r_wait <= r_wait + CNT_ONE;
          end
        end
        ST_IDLE, ST_SRAM_RSP, ST_PER_RSP, ST_ERR_RSP: begin
          if (w_accept) begin
            r_rsp_we <= data_we_i;
            case (w_region)
              REG_SRAM: begin
                r_state <= ST_SRAM_RSP;
              end
              REG_MMIO: begin
                r_per_req   <= 1'b1;
                r_per_we    <= data_we_i;
                r_per_addr  <= data_addr_i;
                r_per_wstrb <= data_wstrb_i;
                r_per_wdata <= data_wdata_i;
                r_wait      <= {CW{1'b0}};
                r_state     <= ST_PER_WAIT;
              end
              default: begin
                r_err_addr <= data_addr_i;
                r_state    <= ST_ERR_RSP;
              end
            endcase
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
